// File: rtl/reduction_input_queue.sv
// Per-port circular input queues feeding the reduction tree, with ready, sticky overflow and occupancy.
// Optional same-cycle bypass of an empty queue when REDUCTION_Q_BYPASS_EN is defined.
module reduction_input_queue #(
    parameter int FAN_IN       = 6,
    parameter int FLIT_SIZE    = 82,
    parameter int input_Q_size = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FLIT_SIZE*FAN_IN-1:0] flit_in,
    input  logic [FAN_IN-1:0]           flit_in_valid,
    output logic [FAN_IN-1:0]           flit_in_ready,
    output logic [FLIT_SIZE*FAN_IN-1:0] out,
    output logic [FAN_IN-1:0]           out_valid,
    input  logic [FAN_IN-1:0]           tree_avail,
    output logic [FAN_IN-1:0]           overflow,
    output logic [FAN_IN*3-1:0]         occupancy
);

    localparam int PTR_W = (input_Q_size > 1) ? $clog2(input_Q_size) : 1;
    localparam int CNT_W = $clog2(input_Q_size + 1);

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(input_Q_size - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Occupancy is a 3-bit display; deeper queues saturate at 7.
    function automatic logic [2:0] f_sat_occ(input logic [31:0] cnt);
        return (cnt > 32'd7) ? 3'd7 : cnt[2:0];
    endfunction

    for (genvar p = 0; p < FAN_IN; p++) begin : g_q
        logic [FLIT_SIZE-1:0] r_mem [input_Q_size];
        logic [PTR_W-1:0]     r_rd;
        logic [PTR_W-1:0]     r_wr;
        logic [CNT_W-1:0]     r_cnt;
        logic                 r_ovf;
        logic                 w_empty;
        logic                 w_ready;
        logic                 w_push;
        logic                 w_pop;
        logic [FLIT_SIZE-1:0] w_din;

        assign w_din   = flit_in[p*FLIT_SIZE +: FLIT_SIZE];
        assign w_empty = (r_cnt == '0);
        // Ready comes from the registered count only, so a full queue never passes through.
        assign w_ready = (r_cnt < CNT_W'(input_Q_size));
        assign w_pop   = !w_empty && tree_avail[p];

`ifdef REDUCTION_Q_BYPASS_EN
        logic w_byp;
        assign w_byp   = w_empty && flit_in_valid[p];
        // A bypassed flit taken by the tree in the same cycle is never stored.
        assign w_push  = flit_in_valid[p] && w_ready && !(w_byp && tree_avail[p]);
        assign out_valid[p] = !w_empty || flit_in_valid[p];
        assign out[p*FLIT_SIZE +: FLIT_SIZE] = w_empty ? w_din : r_mem[r_rd];
`else
        assign w_push  = flit_in_valid[p] && w_ready;
        assign out_valid[p] = !w_empty;
        assign out[p*FLIT_SIZE +: FLIT_SIZE] = r_mem[r_rd];
`endif

        assign flit_in_ready[p]   = w_ready;
        assign overflow[p]        = r_ovf;
        assign occupancy[p*3 +: 3] = f_sat_occ(32'(r_cnt));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < input_Q_size; i++) begin
                    r_mem[i] <= '0;
                end
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr] <= w_din;
                    r_wr        <= f_next_ptr(r_wr);
                end
                if (w_pop) begin
                    r_rd <= f_next_ptr(r_rd);
                end
                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                if (flit_in_valid[p] && !w_ready) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reduction_input_queue.sv
// Directed self-checking bench for reduction_input_queue (optionally with REDUCTION_Q_BYPASS_EN).
module tb_reduction_input_queue;

    localparam int FAN_IN = 6;
    localparam int FW     = 82;
    localparam int QS     = 5;

    logic                 clk;
    logic                 rst;
    logic [FW*FAN_IN-1:0] flit_in;
    logic [FAN_IN-1:0]    flit_in_valid;
    logic [FAN_IN-1:0]    flit_in_ready;
    logic [FW*FAN_IN-1:0] out;
    logic [FAN_IN-1:0]    out_valid;
    logic [FAN_IN-1:0]    tree_avail;
    logic [FAN_IN-1:0]    overflow;
    logic [FAN_IN*3-1:0]  occupancy;

    int checks;
    int errors;

    reduction_input_queue #(.FAN_IN(FAN_IN), .FLIT_SIZE(FW), .input_Q_size(QS)) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_in      (flit_in),
        .flit_in_valid(flit_in_valid),
        .flit_in_ready(flit_in_ready),
        .out          (out),
        .out_valid    (out_valid),
        .tree_avail   (tree_avail),
        .overflow     (overflow),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] head(input int p);
        return out[p*FW +: FW];
    endfunction

    function automatic logic [2:0] occ(input int p);
        return occupancy[p*3 +: 3];
    endfunction

    task automatic set_in(input int p, input logic [FW-1:0] v);
        flit_in[p*FW +: FW] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 6'h00) begin errors++; $display("FAIL reset_out_valid got %h exp 00", out_valid); end
        checks++; if (flit_in_ready !== 6'h3F) begin errors++; $display("FAIL reset_ready got %h exp 3f", flit_in_ready); end
        checks++; if (overflow !== 6'h00) begin errors++; $display("FAIL reset_overflow got %h exp 00", overflow); end
        checks++; if (occupancy !== 18'h0) begin errors++; $display("FAIL reset_occupancy got %h exp 0", occupancy); end
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out); end
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        tree_avail = '0;
        for (int i = 1; i <= 5; i++) begin
            set_in(0, FW'(i));
            flit_in_valid[0] = 1'b1;
            tick();
            checks++; if (head(0) !== FW'(1)) begin errors++; $display("FAIL fill_head%0d got %h exp 1", i, head(0)); end
            checks++; if (occ(0) !== 3'(i)) begin errors++; $display("FAIL fill_occ%0d got %0d exp %0d", i, occ(0), i); end
        end
        flit_in_valid[0] = 1'b0;
        checks++; if (flit_in_ready[0] !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", flit_in_ready[0]); end
        checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL fill_valid got %b exp 1", out_valid[0]); end
    endtask

    task automatic test_overflow_drain();
        set_in(0, FW'(6));
        flit_in_valid[0] = 1'b1;
        tick();
        flit_in_valid[0] = 1'b0;
        checks++; if (overflow[0] !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow[0]); end
        checks++; if (occ(0) !== 3'd5) begin errors++; $display("FAIL ovf_occ got %0d exp 5", occ(0)); end
        tree_avail[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            checks++; if (head(0) !== FW'(i)) begin errors++; $display("FAIL drain_head%0d got %h exp %h", i, head(0), i); end
            tick();
            if (i == 1) begin
                checks++; if (flit_in_ready[0] !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", flit_in_ready[0]); end
            end
        end
        tree_avail[0] = 1'b0;
        checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid[0]); end
        checks++; if (overflow[0] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow[0]); end
    endtask

    task automatic test_wrap();
        set_in(3, FW'(16));
        flit_in_valid[3] = 1'b1;
        tick();
        tree_avail[3] = 1'b1;
        for (int i = 1; i < 12; i++) begin
            set_in(3, FW'(16 + i));
            checks++; if (head(3) !== FW'(16 + i - 1)) begin errors++; $display("FAIL wrap_head%0d got %h exp %h", i, head(3), 16 + i - 1); end
            tick();
            checks++; if (occ(3) !== 3'd1) begin errors++; $display("FAIL wrap_occ%0d got %0d exp 1", i, occ(3)); end
        end
        flit_in_valid[3] = 1'b0;
        checks++; if (head(3) !== FW'(27)) begin errors++; $display("FAIL wrap_last got %h exp 1b", head(3)); end
        tick();
        tree_avail[3] = 1'b0;
        checks++; if (out_valid[3] !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b exp 0", out_valid[3]); end
    endtask

    task automatic test_all_ports();
        for (int p = 0; p < FAN_IN; p++) set_in(p, FW'(256 + p));
        flit_in_valid = 6'h3F;
        tick();
        for (int p = 0; p < FAN_IN; p++) set_in(p, FW'(512 + p));
        tick();
        flit_in_valid = '0;
        for (int p = 0; p < FAN_IN; p++) begin
            checks++; if (occ(p) !== 3'd2) begin errors++; $display("FAIL all_occ%0d got %0d exp 2", p, occ(p)); end
        end
        tree_avail = 6'b010010;
        tick();
        tree_avail = '0;
        for (int p = 0; p < FAN_IN; p++) begin
            if (p == 1 || p == 4) begin
                checks++; if (occ(p) !== 3'd1) begin errors++; $display("FAIL popd_occ%0d got %0d exp 1", p, occ(p)); end
                checks++; if (head(p) !== FW'(512 + p)) begin errors++; $display("FAIL popd_head%0d got %h exp %h", p, head(p), 512 + p); end
            end else begin
                checks++; if (occ(p) !== 3'd2) begin errors++; $display("FAIL kept_occ%0d got %0d exp 2", p, occ(p)); end
                checks++; if (head(p) !== FW'(256 + p)) begin errors++; $display("FAIL kept_head%0d got %h exp %h", p, head(p), 256 + p); end
            end
        end
    endtask

    task automatic test_async_reset();
        set_in(2, FW'(768));
        flit_in_valid[2] = 1'b1;
        tick();
        flit_in_valid[2] = 1'b0;
        checks++; if (occ(2) !== 3'd3) begin errors++; $display("FAIL pre_rst_occ got %0d exp 3", occ(2)); end
        #1 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 6'h00) begin errors++; $display("FAIL arst_valid got %h exp 00", out_valid); end
        checks++; if (flit_in_ready !== 6'h3F) begin errors++; $display("FAIL arst_ready got %h exp 3f", flit_in_ready); end
        checks++; if (occupancy !== 18'h0) begin errors++; $display("FAIL arst_occ got %h exp 0", occupancy); end
        checks++; if (overflow !== 6'h00) begin errors++; $display("FAIL arst_ovf got %h exp 00", overflow); end
        checks++; if (out !== '0) begin errors++; $display("FAIL arst_out got %h exp 0", out); end
        #1 rst = 1'b1;
        set_in(2, FW'(85));
        flit_in_valid[2] = 1'b1;
        tick();
        flit_in_valid[2] = 1'b0;
        checks++; if (occ(2) !== 3'd1) begin errors++; $display("FAIL post_rst_occ got %0d exp 1", occ(2)); end
        checks++; if (head(2) !== FW'(85)) begin errors++; $display("FAIL post_rst_head got %h exp 55", head(2)); end
        tree_avail[2] = 1'b1;
        tick();
        tree_avail[2] = 1'b0;
    endtask

    task automatic test_bypass();
        set_in(5, FW'(171));
        flit_in_valid[5] = 1'b1;
        tree_avail[5]    = 1'b1;
        #1;
`ifdef REDUCTION_Q_BYPASS_EN
        checks++; if (out_valid[5] !== 1'b1) begin errors++; $display("FAIL byp_valid got %b exp 1", out_valid[5]); end
        checks++; if (head(5) !== FW'(171)) begin errors++; $display("FAIL byp_head got %h exp ab", head(5)); end
        tick();
        flit_in_valid[5] = 1'b0;
        tree_avail[5]    = 1'b0;
        #1;
        checks++; if (occ(5) !== 3'd0) begin errors++; $display("FAIL byp_occ got %0d exp 0", occ(5)); end
        checks++; if (out_valid[5] !== 1'b0) begin errors++; $display("FAIL byp_after got %b exp 0", out_valid[5]); end
`else
        checks++; if (out_valid[5] !== 1'b0) begin errors++; $display("FAIL nobyp_valid got %b exp 0", out_valid[5]); end
        tick();
        flit_in_valid[5] = 1'b0;
        tree_avail[5]    = 1'b0;
        #1;
        checks++; if (occ(5) !== 3'd1) begin errors++; $display("FAIL nobyp_occ got %0d exp 1", occ(5)); end
        checks++; if (head(5) !== FW'(171)) begin errors++; $display("FAIL nobyp_head got %h exp ab", head(5)); end
`endif
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        flit_in       = '0;
        flit_in_valid = '0;
        tree_avail    = '0;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_wrap();
        test_all_ports();
        test_async_reset();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reduction_input_queue.md
# reduction_input_queue

Per-port input buffering stage placed directly upstream of the reduction tree in the collective router. Holds up to `input_Q_size` flits for each of `FAN_IN` router ports and presents each queue head to the tree with a valid flag. Pops a head only when the tree asserts the matching availability bit. Provides per-port ready (back-pressure) and a sticky overflow flag to the link side.

## Interface
- `FAN_IN`, 6, number of ports / queues (equals `PORT_NUM`)
- `FLIT_SIZE`, 82, flit width in bits
- `input_Q_size`, 5, depth of each queue in flits; any value ≥ 2, not restricted to powers of two
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flit_in`  in  FLIT_SIZE*FAN_IN  incoming flits; port p occupies bits [p*FLIT_SIZE +: FLIT_SIZE]
- `flit_in_valid`  in  FAN_IN  per-port push request
- `flit_in_ready`  out  FAN_IN  per-port "queue not full"
- `out`  out  FLIT_SIZE*FAN_IN  queue head flits to tree, same packing as `flit_in`
- `out_valid`  out  FAN_IN  per-port "head flit present"
- `tree_avail`  in  FAN_IN  per-port pop grant from tree (connects to the tree's `in_avail`)
- `overflow`  out  FAN_IN  sticky per-port "push attempted while full"
- `occupancy`  out  FAN_IN*3  per-port flit count, 3 bits per port, saturating display of count

## Operation
- FAN_IN identical, independent circular queues; each has storage of input_Q_size entries, rd_ptr, wr_ptr, and count (0..input_Q_size).
- Push: `flit_in_valid[p] & flit_in_ready[p]` -> write `mem[wr_ptr]`; wr_ptr increments, wrapping from input_Q_size-1 to 0.
- Pop: `out_valid[p] & tree_avail[p]` -> rd_ptr increments with the same wrap rule. The flit is not cleared.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- `flit_in_ready[p]` = (count < input_Q_size), taken from the registered count. On a full queue, a push is refused even if a pop happens in the same cycle; no full-queue pass-through.
- `out_valid[p]` = (count != 0). `out[p]` = `mem[rd_ptr]`, driven combinationally from registers.
- Overflow: `flit_in_valid[p] & ~flit_in_ready[p]` -> the flit is dropped and `overflow[p]` sets. It clears only on reset.
- `tree_avail[p]` while `out_valid[p]`=0 is ignored; pointers and count are unchanged.
- `occupancy[p]` = min(count, 7).
- Reset (asserted at any time, including mid-transfer): all pointers, counts and storage go to 0. Queued flits are discarded.
- Reset values of outputs: `out`=0, `out_valid`=0, `flit_in_ready`=all 1, `overflow`=0, `occupancy`=0.

## Timing
- Push-to-head latency is 1 cycle. A flit pushed at edge N shows `out_valid`=1 after edge N.
- The pop takes effect at the edge where `out_valid & tree_avail` is sampled high. The next head, or `out_valid`=0, is visible after that edge.
- Sustained throughput is 1 flit/cycle/port when the queue is neither empty nor full.
- `flit_in_ready` deasserts in the cycle after the push that fills the queue. It reasserts in the cycle after the first pop from full.
- Reset deassertion: the first push is accepted at the first rising edge after `rst` goes high.

## Configuration
- `REDUCTION_Q_BYPASS_EN` defined: for an empty queue with `flit_in_valid[p]`=1, `out[p]` = `flit_in[p]` and `out_valid[p]`=1 in the same cycle (0-cycle latency).
  - If `tree_avail[p]` is also 1 in that cycle, the flit is consumed directly. It is never written, and the pointers and count are unchanged.
  - Otherwise it is written as a normal push.
- Not defined: latency is 1 cycle as above, and `out`/`out_valid` depend on registered state only.

## Test plan
- Reset, then hold `tree_avail`=0 and push 0x1, 0x2, 0x3, 0x4, 0x5 on port 0 -> `occupancy[0]`=5 and `flit_in_ready[0]`=0 after the 5th edge; `out[0]`=0x1 throughout.
- Full port 0, push 0x6 -> 0x6 dropped and `overflow[0]`=1. Then pop 5 times -> heads 0x1..0x5 in order; `out_valid[0]`=0 after the 5th pop and `overflow[0]` still 1.
- Continuous push and pop on port 3 for 12 cycles with values 0x10..0x1B -> output order is preserved across two pointer wraps, and `occupancy[3]` stays constant at 1.
- All 6 ports pushed with distinct values in the same cycle; pop only ports 1 and 4 -> only those counts decrement, and the other heads are unchanged.
- Assert `rst` low mid-stream with 3 flits queued on port 2 -> immediately `out_valid`=0, `flit_in_ready`=all 1, `occupancy`=0.
- With `REDUCTION_Q_BYPASS_EN`: empty port 5, `flit_in_valid`=1 and `tree_avail`=1 with data 0xAB -> `out[5]`=0xAB and `out_valid[5]`=1 in the same cycle; count is 0 after the edge.
